// File: rtl/inst_encoder_pkg.sv
// ============================================================================
// inst_encoder_pkg : RV32I opcodes, request class encodings, encoder FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;

  // Bits that must all equal the sign bit for the immediate to fit its field
  localparam logic [31:0] IMM_I_MASK = 32'hFFFF_F800;
  localparam logic [31:0] IMM_B_MASK = 32'hFFFF_F000;
  localparam logic [31:0] IMM_J_MASK = 32'hFFF0_0000;

  typedef enum logic [3:0] {
    CLS_LW     = 4'd0,
    CLS_SW     = 4'd1,
    CLS_OPIMM  = 4'd2,
    CLS_BRANCH = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_OP     = 4'd6,
    CLS_AUIPC  = 4'd7,
    CLS_JALR   = 4'd8
  } inst_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  function automatic logic imm_fits(input logic [31:0] v, input logic [31:0] m);
    return ((v & m) == 32'd0) || ((v & m) == m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encoder_pack.sv
// ============================================================================
// inst_pack : combinational field bundle -> RV32I word, plus legality flag
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [2:0]  funct3_i,
  input  logic        f7_5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  inst_class_e w_cls;
  logic        w_i_ok;
  logic        w_b_ok;
  logic        w_j_ok;
  logic        w_u_ok;
  logic        w_sh_ok;
  logic        w_is_shift;

  assign w_cls      = inst_class_e'(class_i);
  assign w_i_ok     = imm_fits(imm_i, IMM_I_MASK);
  assign w_b_ok     = imm_fits(imm_i, IMM_B_MASK) & ~imm_i[0];
  assign w_j_ok     = imm_fits(imm_i, IMM_J_MASK) & ~imm_i[0];
  assign w_u_ok     = (imm_i[11:0] == 12'd0);
  assign w_sh_ok    = (imm_i[31:5] == 27'd0);
  assign w_is_shift = (funct3_i == F3_SLL) | (funct3_i == F3_SRX);

  always_comb begin
    word_o  = 32'd0;
    legal_o = 1'b0;
    case (w_cls)
      CLS_LW: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
        legal_o = w_i_ok & (funct3_i == F3_WORD);
      end
      CLS_SW: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
        legal_o = w_i_ok & (funct3_i == F3_WORD);
      end
      CLS_OPIMM: begin
        if (w_is_shift) begin
          word_o  = {1'b0, f7_5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
          legal_o = w_sh_ok;
        end else begin
          word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
          legal_o = w_i_ok;
        end
      end
      CLS_BRANCH: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], OPC_BRANCH};
        legal_o = w_b_ok;
      end
      CLS_JAL: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        legal_o = w_j_ok;
      end
      CLS_LUI: begin
        word_o  = {imm_i[31:12], rd_i, OPC_LUI};
        legal_o = w_u_ok;
      end
      CLS_OP: begin
        word_o  = {1'b0, f7_5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
        legal_o = 1'b1;
      end
      CLS_AUIPC: begin
        word_o  = {imm_i[31:12], rd_i, OPC_AUIPC};
        legal_o = w_u_ok;
      end
      CLS_JALR: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
        legal_o = w_i_ok & (funct3_i == F3_JALR);
      end
      default: begin
        word_o  = 32'd0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// ============================================================================
// inst_encoder : encodes field bundles and streams words to instruction RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7_5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              full,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]  CNT_MAX  = '1;

  enc_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_last_pending;
  logic              w_out_fire;
  logic              w_in_fire;

  inst_pack u_pack (
    .class_i  (in_class),
    .funct3_i (in_funct3),
    .f7_5_i   (in_f7_5),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .word_o   (w_word),
    .legal_o  (w_legal)
  );

  // Once the top-address word is waiting, nothing more may enter
  assign w_last_pending = out_valid_q & (addr_q == ADDR_MAX);
  assign w_out_fire     = out_valid_q & out_ready;
  assign in_ready       = (state_q == ST_RUN) & ~start & (~out_valid_q | out_ready) & ~w_last_pending;
  assign w_in_fire      = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (start) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
      addr_d      = '0;
      err_d       = 1'b0;
      err_cnt_d   = '0;
    end else begin
      if (w_out_fire) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = ST_FULL;
        end
      end
      // A new word may overwrite the one leaving in the same edge
      if (w_in_fire) begin
        if (w_legal) begin
          out_valid_d = 1'b1;
          out_data_d  = w_word;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = addr_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// tb_inst_encoder : scoreboard bench for inst_encoder with a field-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_inst_encoder;

  localparam int AW  = 2;
  localparam int EW  = 3;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready, in_f7_5;
  logic [3:0]    in_class;
  logic [2:0]    in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          in_ready, out_valid, full, err;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic [EW-1:0] err_cnt;

  inst_encoder #(.ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_f7_5(in_f7_5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .full(full), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] word; } exp_t;
  exp_t        sb[$];
  int          n_vec = 0, n_miscmp = 0;
  int          pushed = 0, exp_cnt = 0;
  bit          started = 0, exp_err = 0, fired = 0, force_en = 0;
  logic [31:0] force_word = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miscmp++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int pos);
    return v << pos;
  endfunction

  // Field-level reference: legality from integer ranges, word from field placement
  function automatic bit ref_encode(input int cls, input int f3, input int f75, input int rd,
                                    input int rs1, input int rs2, input int imm,
                                    output logic [31:0] w);
    int          op [9] = '{3, 35, 19, 99, 111, 55, 51, 23, 103};
    logic [31:0] u;
    logic [31:0] regs;
    bit          ok;
    u  = imm;
    w  = 32'd0;
    ok = 0;
    if (cls > 8) return 0;
    regs = fld(rd, 7) | fld(f3, 12) | fld(rs1, 15) | op[cls];
    case (cls)
      0, 8: begin
        ok = imm >= -2048 && imm <= 2047 && f3 == ((cls == 0) ? 2 : 0);
        w  = fld(u & 32'hFFF, 20) | regs;
      end
      1: begin
        ok = imm >= -2048 && imm <= 2047 && f3 == 2;
        w  = fld((u >> 5) & 32'h7F, 25) | fld(rs2, 20) | fld(rs1, 15) | fld(f3, 12)
             | fld(u & 32'h1F, 7) | op[cls];
      end
      2: begin
        if (f3 == 1 || f3 == 5) begin
          ok = imm >= 0 && imm <= 31;
          w  = fld(f75, 30) | fld(u & 32'h1F, 20) | regs;
        end else begin
          ok = imm >= -2048 && imm <= 2047;
          w  = fld(u & 32'hFFF, 20) | regs;
        end
      end
      3: begin
        ok = imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
        w  = fld(u[12], 31) | fld((u >> 5) & 32'h3F, 25) | fld(rs2, 20) | fld(rs1, 15)
             | fld(f3, 12) | fld((u >> 1) & 32'hF, 8) | fld(u[11], 7) | op[cls];
      end
      4: begin
        ok = imm >= -(1 << 20) && imm <= (1 << 20) - 2 && (imm % 2) == 0;
        w  = fld(u[20], 31) | fld((u >> 1) & 32'h3FF, 21) | fld(u[11], 20)
             | fld((u >> 12) & 32'hFF, 12) | fld(rd, 7) | op[cls];
      end
      5, 7: begin
        ok = (u & 32'hFFF) == 0;
        w  = (u & 32'hFFFF_F000) | fld(rd, 7) | op[cls];
      end
      default: begin
        ok = 1;
        w  = fld(f75, 30) | fld(rs2, 20) | regs;
      end
    endcase
    return ok;
  endfunction

  // One clock: check status against the model at negedge, then update the model
  task automatic cycle();
    logic [31:0] w;
    bit          ok, exp_ov, exp_full, exp_ir;
    @(negedge clk);
    exp_ov   = sb.size() > 0;
    exp_full = started && pushed == CAP && !exp_ov;
    exp_ir   = started && !exp_full && !start && (!exp_ov || out_ready) && !(exp_ov && pushed == CAP);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("full", full, exp_full);
    chk("err", err, exp_err);
    chk("err_cnt", err_cnt, exp_cnt);
    if (start) begin
      sb.delete();
      pushed = 0; started = 1; exp_err = 0; exp_cnt = 0;
    end else if (in_valid && in_ready) begin
      fired = 1;
      ok = ref_encode(int'(in_class), int'(in_funct3), int'(in_f7_5), int'(in_rd),
                      int'(in_rs1), int'(in_rs2), $signed(in_imm), w);
      if (force_en) begin ok = 1; w = force_word; end
      if (ok) begin
        sb.push_back('{pushed, w});
        pushed++;
      end else begin
        exp_err = 1;
        if (exp_cnt < (1 << EW) - 1) exp_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_fields(input int cls, input int f3, input int f75, input int rd,
                            input int rs1, input int rs2, input logic [31:0] imm);
    in_class = 4'(cls); in_funct3 = 3'(f3); in_f7_5 = 1'(f75);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  task automatic offer(input int cls, input int f3, input int f75, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
    set_fields(cls, f3, f75, rd, rs1, rs2, imm);
    in_valid = 1; fired = 0;
    for (int i = 0; i < 20 && !fired; i++) cycle();
    if (!fired) begin
      n_vec++; n_miscmp++;
      $display("FAIL accept_timeout: bundle class %0d not taken in 20 cycles, required acceptance", cls);
    end
    in_valid = 0; force_en = 0;
  endtask

  task automatic offer_const(input logic [31:0] wexp, input int cls, input int f3, input int rd,
                             input int rs1, input int rs2, input logic [31:0] imm);
    force_en = 1; force_word = wexp;
    offer(cls, f3, 0, rd, rs1, rs2, imm);
  endtask

  task automatic do_start();
    in_valid = 0; out_ready = 0; start = 1;
    cycle();
    start = 0;
  endtask

  task automatic rand_fields();
    int bnd [20] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, -(1 << 20) - 2,
                     -(1 << 20), (1 << 20) - 2, (1 << 20), 0, 31, 32, -1, 1, 'h1000, 'h1001};
    int m;
    in_class  = ($urandom_range(0, 99) < 5) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    in_funct3 = 3'($urandom_range(0, 7));
    if ((in_class == 0 || in_class == 1) && $urandom_range(0, 9) < 7) in_funct3 = 3'd2;
    if (in_class == 8 && $urandom_range(0, 9) < 7) in_funct3 = 3'd0;
    in_f7_5 = 1'($urandom_range(0, 1));
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    m = int'($urandom_range(0, 9));
    if (m == 0)      in_imm = bnd[$urandom_range(0, 19)];
    else if (m == 1) in_imm = $urandom;
    else case (in_class)
      4'd2:       in_imm = (in_funct3 == 1 || in_funct3 == 5) ? 32'($urandom_range(0, 31))
                                                            : 32'(int'($urandom_range(0, 4095)) - 2048);
      4'd3:       in_imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      4'd4:       in_imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
      4'd5, 4'd7: in_imm = $urandom & 32'hFFFF_F000;
      default:    in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    endcase
  endtask

  // Monitor: every RAM write must match the oldest expected word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst !== 1'b1 && start !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++; n_miscmp++;
          $display("FAIL ram_write: got word %h at addr %0d, required no write", out_data, out_addr);
        end else begin
          e = sb.pop_front();
          chk("out_addr", 32'(out_addr), e.addr);
          chk("out_data", out_data, e.word);
        end
      end
    end
  end

  initial begin
    rst = 0; start = 0; in_valid = 0; out_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0, 32'd0);
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    cycle();

    // Known encodings and addresses
    do_start(); out_ready = 1;
    offer_const(32'hFFB00093, 2, 0, 1, 0, 0, -5);
    cycle();
    do_start(); out_ready = 1;
    offer_const(32'h0020A423, 1, 2, 0, 1, 2, 8);
    offer_const(32'hFE000CE3, 3, 0, 0, 0, 0, -8);
    offer_const(32'h001000EF, 4, 0, 1, 0, 0, 2048);
    offer(2, 0, 0, 3, 0, 0, 7);
    cycle(); cycle();

    // Capacity reached: fifth bundle must be refused
    set_fields(2, 0, 0, 4, 0, 0, 1);
    in_valid = 1; fired = 0;
    repeat (5) cycle();
    chk("fifth_refused", 32'(fired), 0);
    in_valid = 0;
    do_start();
    chk("addr_after_start", 32'(out_addr), 0);

    // Illegal requests are dropped and counted
    out_ready = 1;
    offer(2, 0, 0, 1, 0, 0, 2048);
    offer(3, 1, 0, 0, 1, 2, 3);
    offer(5, 0, 0, 1, 0, 0, 32'h1001);
    cycle();
    chk("illegal_err_cnt", 32'(err_cnt), 3);
    chk("illegal_addr", 32'(out_addr), 0);

    // Backpressure: held word stays stable, nothing else enters
    do_start();
    offer(6, 0, 1, 3, 4, 5, 0);
    set_fields(2, 0, 0, 6, 7, 0, 100);
    in_valid = 1;
    repeat (5) begin
      cycle();
      if (sb.size() > 0) chk("hold_data", out_data, sb[0].word);
    end
    out_ready = 1;
    offer(2, 0, 0, 6, 7, 0, 100);
    cycle(); cycle();

    // Start while a word is pending discards it
    do_start();
    offer(6, 0, 0, 1, 2, 3, 0);
    cycle();
    do_start();
    out_ready = 1;
    repeat (3) cycle();

    // Asynchronous reset while a word is pending
    do_start();
    offer(6, 0, 0, 1, 2, 3, 0);
    cycle();
    #2 rst = 1;
    #1 chk("async_rst_valid", out_valid, 0);
    sb.delete(); started = 0; pushed = 0; exp_err = 0; exp_cnt = 0;
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    repeat (3) cycle();

    // Randomized traffic
    do_start();
    for (int it = 0; it < 3000; it++) begin
      if ((started && pushed == CAP && sb.size() == 0 && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 199) == 0) begin
        do_start();
      end else begin
        out_ready = ($urandom_range(0, 9) < 7);
        in_valid  = ($urandom_range(0, 9) < 6);
        rand_fields();
        cycle();
      end
    end

    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
    chk("drain_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
